// File: rtl/skylark_dmem.sv
// skylark_dmem: word-organised data memory for the skylark-v RV32I core.
//
// The core presents a byte address (ALUResultW), write data and a write
// strobe. Read data is returned combinationally from the current address.
// Writes take effect on the rising clock edge. Reset is synchronous and
// active-high, and it clears every word in a single cycle.
//
// Optional feature macro: DMEM_FAULT_EN
//   When this macro is defined, the block gains the outputs fault and
//   fault_sticky.
//   - fault flags an out-of-range address or a misaligned address.
//   - Misaligned writes are suppressed. Misaligned reads still return the
//     addressed word.
//   When this macro is not defined, those ports do not exist and a[1:0] is
//   simply ignored.
module skylark_dmem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd
`ifdef DMEM_FAULT_EN
  ,
  output logic        fault,
  output logic        fault_sticky
`endif
);

  // Number of addressable bytes. It is computed with two extra bits so that
  // the comparison below cannot overflow for any legal DEPTH.
  localparam logic [33:0] BYTE_SPAN = 34'(DEPTH) * 34'd4;

  // Storage, current and next state.
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  // Word index and address qualifiers.
  logic [AW-1:0] word_idx_s;
  logic          in_range_s;
  logic          wr_ok_s;

  // Returns 1 when the byte address falls inside the populated words.
  // Upper address bits must be zero. Nothing aliases and nothing wraps.
  function automatic logic addr_in_range(input logic [31:0] addr);
    addr_in_range = ({2'b00, addr} < BYTE_SPAN);
  endfunction

  // Returns 1 when the byte address is word aligned.
  function automatic logic addr_aligned(input logic [1:0] low_bits);
    addr_aligned = (low_bits == 2'b00);
  endfunction

  assign word_idx_s = a[AW+1:2];
  assign in_range_s = addr_in_range(a);

`ifdef DMEM_FAULT_EN
  logic fault_s;
  logic fault_sticky_q;
  logic fault_sticky_d;

  assign fault_s      = (!in_range_s) || (!addr_aligned(a[1:0]));
  assign fault        = fault_s;
  assign fault_sticky = fault_sticky_q;

  // Decide whether this cycle's write may land.
  // A write is allowed only for an in-range, aligned address with an
  // asserted strobe.
  always_comb begin
    wr_ok_s = 1'b0;
    if ((we == 1'b1) && in_range_s && addr_aligned(a[1:0])) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Next state of the sticky fault flag.
  // The flag sets on a faulting write attempt and holds until reset.
  // Reset wins over a simultaneous set.
  always_comb begin
    fault_sticky_d = fault_sticky_q;
    if (reset == 1'b1) begin
      fault_sticky_d = 1'b0;
    end else if (fault_s && (we == 1'b1)) begin
      fault_sticky_d = 1'b1;
    end else begin
      fault_sticky_d = fault_sticky_q;
    end
  end

  // Sticky fault flag register.
  always_ff @(posedge clk) begin
    fault_sticky_q <= fault_sticky_d;
  end
`else
  // Decide whether this cycle's write may land.
  // Only the strobe and the range matter here. The low address bits are
  // ignored, so a misaligned address writes the word it falls in.
  always_comb begin
    wr_ok_s = 1'b0;
    if ((we == 1'b1) && in_range_s) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end
`endif

  // Next memory contents.
  // Reset clears every word and beats a simultaneous write.
  // An unknown strobe never selects the write branch, so it cannot corrupt
  // the stored data.
  always_comb begin
    mem_d = mem_q;
    if (reset == 1'b1) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = 32'h0000_0000;
      end
    end else if (wr_ok_s == 1'b1) begin
      mem_d[word_idx_s] = wd;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage register array.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read with zero latency.
  // There is no write bypass, so a same-cycle write becomes visible only
  // after the clock edge.
  always_comb begin
    rd = 32'h0000_0000;
    if (in_range_s) begin
      rd = mem_q[word_idx_s];
    end else begin
      rd = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_skylark_dmem.sv
// Self-checking bench for skylark_dmem.
// It runs directed steps from the test plan and then randomized traffic.
// Every result is compared against a word-array reference model.
module tb_skylark_dmem;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
`ifdef DMEM_FAULT_EN
  logic        fault;
  logic        fault_sticky;
`endif

  int total;
  int bad;

  // Reference model state.
  logic [31:0] model_mem [DEPTH];
  logic        model_sticky;

  skylark_dmem #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd)
`ifdef DMEM_FAULT_EN
    ,
    .fault       (fault),
    .fault_sticky(fault_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_in_range(input logic [31:0] addr);
    return (64'(addr) < 64'(DEPTH) * 64'd4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (model_in_range(addr)) return model_mem[addr / 32'd4];
    return 32'h0;
  endfunction

  function automatic logic model_fault(input logic [31:0] addr);
    return (!model_in_range(addr)) || ((addr % 32'd4) != 32'd0);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply the next set of inputs, then let them settle away from the clock edge.
  task automatic drive(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
    reset = r;
    we    = w;
    a     = addr;
    wd    = data;
    #1;
  endtask

  // Compare the combinational outputs against the model for the current address.
  task automatic check_now(input string tag);
    check32(tag, rd, model_read(a));
`ifdef DMEM_FAULT_EN
    check1({tag, "_fault"}, fault, model_fault(a));
    check1({tag, "_sticky"}, fault_sticky, model_sticky);
`endif
  endtask

  // Advance one rising edge and apply the specification's update rules to the model.
  task automatic tick();
    logic allow;
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      model_sticky = 1'b0;
    end else begin
      allow = (we === 1'b1) && model_in_range(a);
`ifdef DMEM_FAULT_EN
      allow = allow && ((a % 32'd4) == 32'd0);
      if ((we === 1'b1) && model_fault(a)) model_sticky = 1'b1;
`endif
      if (allow) model_mem[a / 32'd4] = wd;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rdat;
    int          sel;
    total = 0;
    bad   = 0;
    model_sticky = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset for one edge, then read several addresses.
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h00, 32'h0); check32("rst_rd_00", rd, 32'h0);
`ifdef DMEM_FAULT_EN
    check1("rst_sticky", fault_sticky, 1'b0);
`endif
    drive(1'b0, 1'b0, 32'h04, 32'h0); check32("rst_rd_04", rd, 32'h0);
    drive(1'b0, 1'b0, 32'hFC, 32'h0); check32("rst_rd_fc", rd, 32'h0);

    // Basic write. The old value stays visible until the edge.
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    check32("wr10_pre", rd, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h10, 32'h0); check32("wr10_post", rd, 32'hDEADBEEF);

    // Writes at both ends of the array must not overlap.
    drive(1'b0, 1'b1, 32'h00, 32'h11111111); tick();
    drive(1'b0, 1'b1, 32'hFC, 32'h22222222); tick();
    drive(1'b0, 1'b0, 32'h00, 32'h0); check32("ends_00", rd, 32'h11111111);
    drive(1'b0, 1'b0, 32'hFC, 32'h0); check32("ends_fc", rd, 32'h22222222);

    // An out-of-range write is dropped.
    drive(1'b0, 1'b1, 32'h100, 32'hCAFEBABE);
`ifdef DMEM_FAULT_EN
    check1("oor_fault", fault, 1'b1);
`endif
    tick();
    check32("oor_rd", rd, 32'h0);
`ifdef DMEM_FAULT_EN
    check1("oor_sticky", fault_sticky, 1'b1);
`endif
    drive(1'b0, 1'b0, 32'h00, 32'h0); check32("oor_00_kept", rd, 32'h11111111);

    // An unknown strobe must leave memory unchanged.
    drive(1'b0, 1'bx, 32'h10, 32'h0BADF00D); tick();
    drive(1'b0, 1'b0, 32'h10, 32'h0); check32("we_x", rd, 32'hDEADBEEF);

    // With we held high, one write lands per edge and the last value wins.
    drive(1'b0, 1'b1, 32'h30, 32'h00000001); tick();
    drive(1'b0, 1'b1, 32'h30, 32'h00000002); tick();
    drive(1'b0, 1'b1, 32'h30, 32'h00000003); tick();
    drive(1'b0, 1'b0, 32'h30, 32'h0); check32("multi_wr", rd, 32'h00000003);

    // Misaligned write.
    drive(1'b0, 1'b1, 32'h20, 32'h5A5A5A5A); tick();
    drive(1'b0, 1'b1, 32'h22, 32'hA5A5A5A5);
`ifdef DMEM_FAULT_EN
    check1("mis_fault", fault, 1'b1);
    check32("mis_rd_pre", rd, 32'h5A5A5A5A);
`endif
    tick();
    drive(1'b0, 1'b0, 32'h20, 32'h0);
`ifdef DMEM_FAULT_EN
    check32("mis_kept", rd, 32'h5A5A5A5A);
`else
    check32("mis_written", rd, 32'hA5A5A5A5);
`endif

    // Reset beats a simultaneous write and clears earlier data.
    drive(1'b1, 1'b1, 32'h20, 32'h12345678); tick();
    drive(1'b0, 1'b0, 32'h20, 32'h0); check32("rstprio_20", rd, 32'h0);
    drive(1'b0, 1'b0, 32'h10, 32'h0); check32("rstprio_10", rd, 32'h0);
`ifdef DMEM_FAULT_EN
    check1("rstprio_sticky", fault_sticky, 1'b0);
`endif
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Randomized traffic checked against the model.
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70) ra = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      else if (sel < 85) ra = 32'($urandom_range(0, DEPTH * 4 - 1));
      else if (sel < 95) ra = 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 64));
      else ra = $urandom;
      rdat = $urandom;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), ra, rdat);
      check_now("rnd_pre");
      tick();
      check_now("rnd_post");
      drive(1'b0, 1'b0, 32'($urandom_range(0, DEPTH - 1)) * 32'd4, 32'h0);
      check_now("rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
